// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-setting controller: FSM states,
// one-hot reload codes, digit indices and per-digit maxima.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_MU,
        ST_SET_MT,
        ST_SET_HU,
        ST_SET_HT
    } state_t;

    localparam logic [4:0] RC_NONE = 5'b00001;
    localparam logic [4:0] RC_9    = 5'b00010;
    localparam logic [4:0] RC_5    = 5'b00100;
    localparam logic [4:0] RC_3    = 5'b01000;
    localparam logic [4:0] RC_2    = 5'b10000;

    localparam logic [1:0] DIG_MU = 2'd0;
    localparam logic [1:0] DIG_MT = 2'd1;
    localparam logic [1:0] DIG_HU = 2'd2;
    localparam logic [1:0] DIG_HT = 2'd3;

    localparam logic [3:0] MAX_MU    = 4'd9;
    localparam logic [3:0] MAX_MT    = 4'd5;
    localparam logic [3:0] MAX_HU    = 4'd9;
    localparam logic [3:0] MAX_HU_LO = 4'd3;
    localparam logic [3:0] MAX_HT    = 4'd2;

    // Hour units only reach 9 while hour tens is below 2 (caps at 23).
    function automatic logic [3:0] digit_max(input logic [1:0] idx, input logic [3:0] ht_val);
        logic [3:0] m;
        case (idx)
            DIG_MU:  m = MAX_MU;
            DIG_MT:  m = MAX_MT;
            DIG_HU:  m = (ht_val == MAX_HT) ? MAX_HU_LO : MAX_HU;
            default: m = MAX_HT;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] rc_for_max(input logic [3:0] max_val);
        logic [4:0] rc;
        case (max_val)
            4'd9:    rc = RC_9;
            4'd5:    rc = RC_5;
            4'd3:    rc = RC_3;
            4'd2:    rc = RC_2;
            default: rc = RC_NONE;
        endcase
        return rc;
    endfunction

    function automatic logic [1:0] state_to_sel(input state_t st);
        logic [1:0] s;
        case (st)
            ST_SET_MT: s = DIG_MT;
            ST_SET_HU: s = DIG_HU;
            ST_SET_HT: s = DIG_HT;
            default:   s = DIG_MU;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alarm_digit_cmd.sv
// Per-digit command mapper: turns an up/down/clear request plus the digit's
// current value and maximum into add/sub/clear strobes and a reload code.
module alarm_digit_cmd
    import alarm_pkg::*;
(
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_clr,
    input  logic [3:0] i_value,
    input  logic [3:0] i_max,
    output logic       o_add,
    output logic       o_sub,
    output logic       o_clear,
    output logic [4:0] o_reload
);

    always_comb begin
        o_add    = 1'b0;
        o_sub    = 1'b0;
        o_clear  = 1'b0;
        o_reload = RC_NONE;
        if (i_clr) begin
            o_clear = 1'b1;
        end else if (i_up) begin
            // Values above max (including garbage >9) wrap to zero.
            if (i_value >= i_max)
                o_clear = 1'b1;
            else
                o_add = 1'b1;
        end else if (i_down) begin
            if (i_value == 4'd0)
                o_reload = rc_for_max(i_max);
            else
                o_sub = 1'b1;
        end
    end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm-setting controller: set-mode FSM, key lockout, hour clamp and optional
// idle timeout (enabled by defining ALARM_SET_TIMEOUT_EN).
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic        i_sysclk,
    input  logic        i_rst,
    input  logic        i_key_mode,
    input  logic        i_key_next,
    input  logic        i_key_up,
    input  logic        i_key_down,
    input  logic        i_key_clr,
    input  logic [15:0] i_digit_val,
    output logic [3:0]  o_alarm_add,
    output logic [3:0]  o_alarm_sub,
    output logic [3:0]  o_alarm_clear,
    output logic [3:0]  o_alarm_keep,
    output logic [19:0] o_alarm_reset,
    output logic        o_set_active,
    output logic [1:0]  o_sel
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_strobe;
    logic [3:0]  r_add, r_sub, r_clear, r_keep;
    logic [19:0] r_reset;
    logic        r_set_active;
    logic [1:0]  r_sel;

    logic [3:0]  w_add_next, w_sub_next, w_clear_next, w_keep_next;
    logic [19:0] w_reset_next;
    logic        w_set_active_next;
    logic [1:0]  w_sel_next;

    logic [3:0]  w_add, w_sub, w_clear;
    logic [19:0] w_reload;
    logic [1:0]  w_sel_cur;
    logic        w_in_set, w_key_ok, w_timeout, w_clamp;
    logic        w_do_clr, w_do_next, w_do_up, w_do_down;
    logic [3:0]  w_d2, w_d3;

    assign w_sel_cur = state_to_sel(r_state);
    assign w_in_set  = (r_state != ST_IDLE);
    assign w_d2      = i_digit_val[11:8];
    assign w_d3      = i_digit_val[15:12];

    // A key landing while a strobe is on the outputs would see stale counter values.
    assign w_key_ok  = w_in_set && !r_strobe && !i_key_mode;
    assign w_do_clr  = w_key_ok && i_key_clr;
    assign w_do_next = w_key_ok && !i_key_clr && i_key_next;
    assign w_do_up   = w_key_ok && !i_key_clr && !i_key_next && i_key_up && !i_key_down;
    assign w_do_down = w_key_ok && !i_key_clr && !i_key_next && i_key_down && !i_key_up;

    assign w_clamp = (w_sel_cur == DIG_HT) && (w_d2 > MAX_HU_LO) &&
                     ((w_do_up && w_d3 == 4'd1) || (w_do_down && w_d3 == 4'd0));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic w_hit;
            assign w_hit = (w_sel_cur == 2'(gi));
            alarm_digit_cmd u_cmd (
                .i_up     (w_do_up && w_hit),
                .i_down   (w_do_down && w_hit),
                .i_clr    (w_do_clr && w_hit),
                .i_value  (i_digit_val[gi*4 +: 4]),
                .i_max    (digit_max(2'(gi), w_d3)),
                .o_add    (w_add[gi]),
                .o_sub    (w_sub[gi]),
                .o_clear  (w_clear[gi]),
                .o_reload (w_reload[gi*5 +: 5])
            );
        end
    endgenerate

`ifdef ALARM_SET_TIMEOUT_EN
    logic [31:0] r_idle_cnt;
    logic        w_accepted;

    assign w_accepted = w_do_clr || w_do_next || w_do_up || w_do_down;
    assign w_timeout  = w_in_set && (r_idle_cnt == TIMEOUT_CYC - 32'd1);

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst)
            r_idle_cnt <= '0;
        else if (!w_in_set || w_accepted)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + 32'd1;
    end
`else
    // No idle timer in this build; the parameter only keeps the interface uniform.
    assign w_timeout = (TIMEOUT_CYC == 32'd0) && 1'b0;
`endif

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_key_mode) w_state_next = ST_SET_MU;
            default: begin
                if (i_key_mode || w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (w_do_next) begin
                    case (r_state)
                        ST_SET_MU: w_state_next = ST_SET_MT;
                        ST_SET_MT: w_state_next = ST_SET_HU;
                        ST_SET_HU: w_state_next = ST_SET_HT;
                        default:   w_state_next = ST_SET_MU;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        w_add_next        = '0;
        w_sub_next        = '0;
        w_clear_next      = '0;
        w_reset_next      = {4{RC_NONE}};
        w_keep_next       = 4'hF;
        w_set_active_next = (w_state_next != ST_IDLE);
        w_sel_next        = state_to_sel(w_state_next);
        if (w_state_next != ST_IDLE) begin
            w_add_next   = w_add;
            w_sub_next   = w_sub;
            w_clear_next = w_clear;
            w_reset_next = w_reload;
            if (w_clamp)
                w_reset_next[14:10] = RC_3;
            w_keep_next = ~(4'b0001 << w_sel_next);
        end
    end

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            r_add        <= '0;
            r_sub        <= '0;
            r_clear      <= '0;
            r_reset      <= {4{RC_NONE}};
            r_keep       <= 4'hF;
            r_set_active <= 1'b0;
            r_sel        <= '0;
            r_strobe     <= 1'b0;
        end else begin
            r_add        <= w_add_next;
            r_sub        <= w_sub_next;
            r_clear      <= w_clear_next;
            r_reset      <= w_reset_next;
            r_keep       <= w_keep_next;
            r_set_active <= w_set_active_next;
            r_sel        <= w_sel_next;
            r_strobe     <= (|w_add_next) || (|w_sub_next) || (|w_clear_next) ||
                            (w_reset_next != {4{RC_NONE}});
        end
    end

    assign o_alarm_add   = r_add;
    assign o_alarm_sub   = r_sub;
    assign o_alarm_clear = r_clear;
    assign o_alarm_reset = r_reset;
    assign o_alarm_keep  = r_keep;
    assign o_set_active  = r_set_active;
    assign o_sel         = r_sel;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed self-checking bench for alarm_set_ctrl; timeout cases run only
// when ALARM_SET_TIMEOUT_EN is defined.
module tb_alarm_set_ctrl;

    localparam logic [4:0] NONE = 5'b00001;
    localparam logic [4:0] L9   = 5'b00010;
    localparam logic [4:0] L3   = 5'b01000;
    localparam logic [4:0] L2   = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_mode = 1'b0, key_next = 1'b0, key_up = 1'b0, key_down = 1'b0, key_clr = 1'b0;
    logic [15:0] digit_val = 16'h0000;
    logic [3:0]  alarm_add, alarm_sub, alarm_clear, alarm_keep;
    logic [19:0] alarm_reset;
    logic        set_active;
    logic [1:0]  sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alarm_set_ctrl #(.TIMEOUT_CYC(32'd10)) dut (
        .i_sysclk      (clk),
        .i_rst         (rst),
        .i_key_mode    (key_mode),
        .i_key_next    (key_next),
        .i_key_up      (key_up),
        .i_key_down    (key_down),
        .i_key_clr     (key_clr),
        .i_digit_val   (digit_val),
        .o_alarm_add   (alarm_add),
        .o_alarm_sub   (alarm_sub),
        .o_alarm_clear (alarm_clear),
        .o_alarm_keep  (alarm_keep),
        .o_alarm_reset (alarm_reset),
        .o_set_active  (set_active),
        .o_sel         (sel)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // keys = {mode, next, up, down, clr}; one-cycle pulse, returns on the
    // falling edge right after the capturing clock edge.
    task automatic key(input logic [4:0] keys);
        @(negedge clk);
        {key_mode, key_next, key_up, key_down, key_clr} = keys;
        @(negedge clk);
        {key_mode, key_next, key_up, key_down, key_clr} = 5'b0;
    endtask

    localparam logic [4:0] K_MODE = 5'b10000;
    localparam logic [4:0] K_NEXT = 5'b01000;
    localparam logic [4:0] K_UP   = 5'b00100;
    localparam logic [4:0] K_DOWN = 5'b00010;
    localparam logic [4:0] K_CLR  = 5'b00001;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_add",    alarm_add,   4'h0);
        check_val("rst_sub",    alarm_sub,   4'h0);
        check_val("rst_clear",  alarm_clear, 4'h0);
        check_val("rst_keep",   alarm_keep,  4'hF);
        check_val("rst_reset",  alarm_reset, {NONE, NONE, NONE, NONE});
        check_val("rst_active", set_active,  1'b0);
        check_val("rst_sel",    sel,         2'd0);
        rst = 1'b0;

        key(K_MODE);
        check_val("enter_active", set_active, 1'b1);
        check_val("enter_sel",    sel,        2'd0);
        check_val("enter_keep",   alarm_keep, 4'b1110);

        digit_val = 16'h0009;
        key(K_UP);
        check_val("mu_up_wrap_clear", alarm_clear, 4'b0001);
        check_val("mu_up_wrap_add",   alarm_add,   4'b0000);
        @(negedge clk);
        check_val("mu_clear_one_cycle", alarm_clear, 4'b0000);

        digit_val = 16'h0000;
        key(K_DOWN);
        check_val("mu_down_wrap_reset", alarm_reset, {NONE, NONE, NONE, L9});
        check_val("mu_down_wrap_sub",   alarm_sub,   4'b0000);

        digit_val = 16'h0004;
        key(K_UP);
        check_val("mu_up_add", alarm_add, 4'b0001);

        key(K_NEXT);
        key(K_NEXT);
        key(K_NEXT);
        check_val("sel_ht",  sel,        2'd3);
        check_val("keep_ht", alarm_keep, 4'b0111);

        digit_val = 16'h1700;
        key(K_UP);
        check_val("ht_up_clamp_add",   alarm_add,   4'b1000);
        check_val("ht_up_clamp_reset", alarm_reset, {NONE, L3, NONE, NONE});

        digit_val = 16'h0500;
        key(K_DOWN);
        check_val("ht_down_wrap_clamp", alarm_reset, {L2, L3, NONE, NONE});

        digit_val = 16'h2000;
        key(K_UP);
        check_val("ht_up_wrap_clear", alarm_clear, 4'b1000);

        key(K_NEXT);
        check_val("sel_wrap_mu", sel, 2'd0);
        key(K_NEXT);
        key(K_NEXT);
        check_val("sel_hu", sel, 2'd2);

        digit_val = 16'h2300;
        key(K_UP);
        check_val("hu_up_at3_clear", alarm_clear, 4'b0100);
        digit_val = 16'h2000;
        key(K_DOWN);
        check_val("hu_down_load3", alarm_reset, {NONE, L3, NONE, NONE});
        digit_val = 16'h1000;
        key(K_DOWN);
        check_val("hu_down_load9", alarm_reset, {NONE, L9, NONE, NONE});

        // key_up held two cycles: second cycle falls in the lockout.
        digit_val = 16'h2100;
        @(negedge clk);
        key_up = 1'b1;
        @(negedge clk);
        check_val("lock_first_add", alarm_add, 4'b0100);
        @(negedge clk);
        key_up = 1'b0;
        check_val("lock_second_dropped", alarm_add, 4'b0000);

        key(K_UP | K_DOWN);
        check_val("updown_add",   alarm_add,   4'b0000);
        check_val("updown_sub",   alarm_sub,   4'b0000);
        check_val("updown_reset", alarm_reset, {NONE, NONE, NONE, NONE});

        key(K_CLR | K_UP);
        check_val("clr_prio_clear", alarm_clear, 4'b0100);
        check_val("clr_prio_add",   alarm_add,   4'b0000);

        key(K_NEXT | K_UP);
        check_val("next_prio_sel", sel,       2'd3);
        check_val("next_prio_add", alarm_add, 4'b0000);

        digit_val = 16'hC000;
        key(K_UP);
        check_val("oor_up_clear", alarm_clear, 4'b1000);
        key(K_DOWN);
        check_val("oor_down_sub", alarm_sub, 4'b1000);

        key(K_MODE);
        check_val("exit_active", set_active, 1'b0);
        check_val("exit_keep",   alarm_keep, 4'hF);
        check_val("exit_sel",    sel,        2'd0);
        digit_val = 16'h0003;
        key(K_UP);
        check_val("idle_up_ignored", alarm_add, 4'b0000);

        key(K_MODE);
        key(K_UP);
        check_val("pre_rst_add", alarm_add, 4'b0001);
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_add",    alarm_add,  4'b0000);
        check_val("async_rst_active", set_active, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ALARM_SET_TIMEOUT_EN
        digit_val = 16'h0000;
        key(K_MODE);
        repeat (9) @(negedge clk);
        check_val("to_still_active", set_active, 1'b1);
        @(negedge clk);
        check_val("to_exit", set_active, 1'b0);

        key(K_MODE);
        repeat (3) @(negedge clk);
        key(K_UP);
        repeat (9) @(negedge clk);
        check_val("to_extended_active", set_active, 1'b1);
        @(negedge clk);
        check_val("to_extended_exit", set_active, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
